// File: rtl/dsp_mac_sequencer_if.sv
// dsp_mac_sequencer_if
//   Bundles the job command, operand stream, DSP48A1 slice bus and result
//   handshake of the MAC sequencer.
//   modport slave  : sequencer side (drives start_ready/s_ready/dsp_*/result*)
//   modport master : environment side (drives start/len/s_*/dsp_p/result_ready)
//   Macro DSP_MAC_SEQ_PREADD_EN adds the pre-adder operand s_d -> dsp_d.
interface dsp_mac_sequencer_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic             start_ready;
    logic [LEN_W-1:0] len;
    logic             s_valid;
    logic             s_ready;
    logic [17:0]      s_a;
    logic [17:0]      s_b;
`ifdef DSP_MAC_SEQ_PREADD_EN
    logic [17:0]      s_d;
    logic [17:0]      dsp_d;
`endif
    logic [17:0]      dsp_a;
    logic [17:0]      dsp_b;
    logic [7:0]       dsp_opmode;
    logic             dsp_ce;
    logic [47:0]      dsp_p;
    logic [47:0]      result;
    logic             result_valid;
    logic             result_ready;
    logic             busy;

    modport slave (
        input  start, len, s_valid, s_a, s_b,
`ifdef DSP_MAC_SEQ_PREADD_EN
        input  s_d,
        output dsp_d,
`endif
        input  dsp_p, result_ready,
        output start_ready, s_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce,
        output result, result_valid, busy
    );

    modport master (
        output start, len, s_valid, s_a, s_b,
`ifdef DSP_MAC_SEQ_PREADD_EN
        output s_d,
        input  dsp_d,
`endif
        output dsp_p, result_ready,
        input  start_ready, s_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce,
        input  result, result_valid, busy
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
//   Drives one DSP48A1 slice as a streaming multiply-accumulate engine.
//   A start command latches a pair count; operand pairs are registered onto
//   the slice A/B inputs and a tag per cycle travels down a shift register
//   that mirrors the slice pipeline. The tag selects the opmode so that it
//   lands in OPMODEREG exactly when its product sits in MREG, and the tag
//   marked "last" leaving the final stage means P holds the dot product.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     io (slave) : start/start_ready/len, s_valid/s_ready/s_a/s_b,
//                  dsp_a/dsp_b/dsp_opmode/dsp_ce/dsp_p,
//                  result/result_valid/result_ready, busy
//   Optional: DSP_MAC_SEQ_PREADD_EN adds s_d -> dsp_d and sets opmode bit4
//   on FIRST/ACC/HOLD so the slice computes sum a*(d+b).
module dsp_mac_sequencer #(
    parameter int LEN_W   = 8,
    parameter int MUL_LAT = 2,
    parameter int OPM_LAT = 1,
    parameter int P_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dsp_mac_sequencer_if.slave   io
);
    localparam int DEPTH   = MUL_LAT + P_LAT;
    localparam int OPM_STG = MUL_LAT - OPM_LAT;

`ifdef DSP_MAC_SEQ_PREADD_EN
    localparam logic [7:0] OP_PRE = 8'h10;
`else
    localparam logic [7:0] OP_PRE = 8'h00;
`endif
    localparam logic [7:0] OP_FIRST = 8'h01 | OP_PRE;  // X=M, Z=0
    localparam logic [7:0] OP_ACC   = 8'h09 | OP_PRE;  // X=M, Z=P
    localparam logic [7:0] OP_HOLD  = 8'h08 | OP_PRE;  // X=0, Z=P
    localparam logic [7:0] OP_IDLE  = 8'h00;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_RESULT} state_t;

    // act: cycle belongs to a job (bubble -> HOLD); outside jobs -> IDLE code
    typedef struct packed {
        logic act;
        logic v;
        logic first;
        logic last;
    } tag_t;

    localparam tag_t TAG_EXIT = '{act: 1'b1, v: 1'b1, first: 1'b0, last: 1'b1};

    state_t            state, state_nxt;
    tag_t [DEPTH:0]    tag_pipe;
    tag_t              tag_in, tag_opm, tag_out;
    logic [LEN_W-1:0]  cnt;
    logic              first_pend;
    logic              start_acc, beat, last_beat, last_exit;

    assign tag_opm   = tag_pipe[OPM_STG];
    assign tag_out   = tag_pipe[DEPTH];
    assign start_acc = (state == S_IDLE) && io.start;
    assign beat      = (state == S_RUN) && io.s_valid;
    assign last_beat = beat && (cnt == LEN_W'(1));
    // first is masked off: a single-pair job's tag is both first and last
    assign last_exit = ((tag_out & TAG_EXIT) == TAG_EXIT);

    assign io.start_ready  = rst_n && (state == S_IDLE);
    assign io.s_ready      = (state == S_RUN);
    assign io.busy         = (state == S_RUN) || (state == S_DRAIN);
    assign io.result_valid = (state == S_RESULT);
    assign io.dsp_ce       = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tag_in    = '0;
        case (state)
            S_IDLE:   if (io.start) state_nxt = (io.len == '0) ? S_RESULT : S_RUN;
            S_RUN: begin
                tag_in = '{act: 1'b1, v: beat, first: first_pend, last: last_beat};
                if (last_beat) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                tag_in.act = 1'b1;
                if (last_exit) state_nxt = S_RESULT;
            end
            S_RESULT: if (io.result_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Combinational off the tag register: appears one cycle before the
    // product reaches M, so OPMODEREG and MREG line up at the P edge.
    always_comb begin
        io.dsp_opmode = OP_IDLE;
        if (tag_opm.act) begin
            if (!tag_opm.v)         io.dsp_opmode = OP_HOLD;
            else if (tag_opm.first) io.dsp_opmode = OP_FIRST;
            else                    io.dsp_opmode = OP_ACC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_pipe   <= '0;
            cnt        <= '0;
            first_pend <= 1'b0;
            io.dsp_a   <= '0;
            io.dsp_b   <= '0;
`ifdef DSP_MAC_SEQ_PREADD_EN
            io.dsp_d   <= '0;
`endif
            io.result  <= '0;
        end else begin
            tag_pipe <= {tag_pipe[DEPTH-1:0], tag_in};
            if (start_acc) begin
                cnt        <= io.len;
                first_pend <= 1'b1;
                if (io.len == '0) io.result <= '0;
            end
            if (beat) begin
                cnt        <= cnt - LEN_W'(1);
                first_pend <= 1'b0;
                io.dsp_a   <= io.s_a;
                io.dsp_b   <= io.s_b;
`ifdef DSP_MAC_SEQ_PREADD_EN
                io.dsp_d   <= io.s_d;
`endif
            end
            if ((state == S_DRAIN) && last_exit) io.result <= io.dsp_p;
        end
    end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a small DSP48A1 slice model closes the loop,
// a job-level model predicts handshake state and the dot product each cycle,
// and directed jobs pin results to hand-computed values.
module tb_dsp_mac_sequencer;
    localparam int LEN_W = 8;
    localparam int LAT   = 4;  // MUL_LAT + P_LAT + 1

`ifdef DSP_MAC_SEQ_PREADD_EN
    localparam logic [7:0] PRE = 8'h10;
`else
    localparam logic [7:0] PRE = 8'h00;
`endif
    localparam logic [7:0] OP_FIRST = 8'h01 | PRE;
    localparam logic [7:0] OP_ACC   = 8'h09 | PRE;
    localparam logic [7:0] OP_HOLD  = 8'h08 | PRE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dsp_mac_sequencer_if #(.LEN_W(LEN_W)) bus();
    dsp_mac_sequencer #(.LEN_W(LEN_W)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- DSP48A1 slice model (A1/B1, M, OPMODE, P regs) -------
    logic signed [17:0] a1, b1;
    logic signed [35:0] mreg;
    logic        [7:0]  opm_r;
    logic        [47:0] preg;
`ifdef DSP_MAC_SEQ_PREADD_EN
    logic signed [17:0] d1;
    logic signed [17:0] db;
    assign db = d1 + b1;
`endif
    assign bus.dsp_p = preg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1 <= '0; b1 <= '0; mreg <= '0; opm_r <= '0; preg <= '0;
`ifdef DSP_MAC_SEQ_PREADD_EN
            d1 <= '0;
`endif
        end else begin
            a1    <= bus.dsp_a;
            b1    <= bus.dsp_b;
`ifdef DSP_MAC_SEQ_PREADD_EN
            d1    <= bus.dsp_d;
            mreg  <= (opm_r[4] | bus.dsp_opmode[4]) ? a1 * db : a1 * b1;
`else
            mreg  <= a1 * b1;
`endif
            opm_r <= bus.dsp_opmode;
            preg  <= ((opm_r[1:0] == 2'b01) ? {{12{mreg[35]}}, mreg} : 48'd0)
                   + ((opm_r[3:2] == 2'b10) ? preg : 48'd0);
        end
    end

    // ---------------- job-level reference model ------------------------------
    // ph: 0 idle, 1 taking pairs, 2 waiting for result, 3 result pending
    int          ph = 0;
    int          m_cnt = 0, m_drain = 0, m_len = 0, m_job = 0;
    logic [47:0] m_acc = '0;
    longint      prod;

    always @(posedge clk) begin
        if (!rst_n) begin
            ph = 0;
            m_acc = '0;
        end else begin
            case (ph)
                0: if (bus.start) begin
                    m_job++;
                    m_len = int'(bus.len);
                    m_acc = '0;
                    if (bus.len == '0) ph = 3;
                    else begin m_cnt = int'(bus.len); ph = 1; end
                end
                1: if (bus.s_valid) begin
                    prod  = longint'($signed(bus.s_a)) * longint'($signed(bus.s_b));
                    m_acc = m_acc + prod[47:0];
                    m_cnt--;
                    if (m_cnt == 0) begin ph = 2; m_drain = LAT; end
                end
                2: if (m_drain == 1) ph = 3; else m_drain--;
                3: if (bus.result_ready) ph = 0;
                default: ph = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare + opmode census ----------------------
    int n_first = 0, n_acc = 0, n_hold_mid = 0, pend_hold = 0, n_nz = 0;
    int seen_job = 0, prev_ph = 0;

    always @(negedge clk) begin
        if (m_job != seen_job) begin
            seen_job = m_job;
            n_first = 0; n_acc = 0; n_hold_mid = 0; pend_hold = 0; n_nz = 0;
        end
        chk("dsp_ce", bus.dsp_ce, 1);
        if (!rst_n) begin
            chk("rst start_ready", bus.start_ready, 0);
            chk("rst s_ready", bus.s_ready, 0);
            chk("rst busy", bus.busy, 0);
            chk("rst result_valid", bus.result_valid, 0);
            chk("rst result", bus.result, 0);
            chk("rst dsp_opmode", bus.dsp_opmode, 0);
            chk("rst dsp_a", bus.dsp_a, 0);
            chk("rst dsp_b", bus.dsp_b, 0);
        end else begin
            chk("start_ready", bus.start_ready, ph == 0);
            chk("s_ready", bus.s_ready, ph == 1);
            chk("busy", bus.busy, (ph == 1) || (ph == 2));
            chk("result_valid", bus.result_valid, ph == 3);
            if (ph == 3) chk("result", bus.result, m_acc);
            if (ph == 3 && prev_ph != 3) begin
                chk("first opmodes", n_first, (m_len > 0) ? 1 : 0);
                chk("acc opmodes", n_acc, (m_len > 0) ? m_len - 1 : 0);
            end
        end
        if (bus.dsp_opmode != 8'h00) n_nz++;
        if (bus.dsp_opmode == OP_FIRST) begin n_first++; pend_hold = 0; end
        else if (bus.dsp_opmode == OP_ACC) begin n_acc++; n_hold_mid += pend_hold; pend_hold = 0; end
        else if (bus.dsp_opmode == OP_HOLD && n_first > 0) pend_hold++;
        prev_ph = ph;
    end

    // ---------------- directed stimulus --------------------------------------
    logic [17:0] pa [256];
    logic [17:0] pb [256];

    // gap_n idle cycles are inserted before pair index gap_at.
    // lat counts cycles from the last accepted pair (or the start accept for
    // len=0) until result_valid is seen.
    task automatic run_job(input int n, input int gap_at, input int gap_n,
                           output logic [47:0] res, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = LEN_W'(n);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                bus.s_valid = 1'b0;
                repeat (gap_n) @(negedge clk);
            end
            bus.s_valid = 1'b1;
            bus.s_a = pa[i];
            bus.s_b = pb[i];
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        lat = 0;
        while (!bus.result_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) chk("result_valid timeout", 0, 1);
        res = bus.result;
    endtask

    logic [47:0] res, res2;
    int lat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.len = '0; bus.s_valid = 1'b0;
        bus.s_a = '0; bus.s_b = '0; bus.result_ready = 1'b1;
`ifdef DSP_MAC_SEQ_PREADD_EN
        bus.s_d = '0;
`endif
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("start_ready after reset", bus.start_ready, 1);

        // 2*3 + 4*5 + (-1)*7 = 19, back-to-back
        pa[0] = 18'd2;  pb[0] = 18'd3;
        pa[1] = 18'd4;  pb[1] = 18'd5;
        pa[2] = 18'h3FFFF; pb[2] = 18'd7;
        run_job(3, -1, 0, res, lat);
        chk("dot3 result", res, 48'd19);
        chk("dot3 latency", lat, 4);
        @(negedge clk);
        chk("dot3 valid pulse", bus.result_valid, 0);
        chk("dot3 mid holds", n_hold_mid, 0);

        // same job with a 2-cycle gap between pairs 1 and 2
        run_job(3, 1, 2, res, lat);
        chk("gap result", res, 48'd19);
        @(negedge clk);
        chk("gap mid holds", n_hold_mid, 2);

        // empty job
        run_job(0, -1, 0, res, lat);
        chk("len0 latency", lat, 0);
        chk("len0 result", res, 48'd0);
        @(negedge clk);
        chk("len0 valid pulse", bus.result_valid, 0);
        chk("len0 opmodes", n_nz, 0);

        // back-pressured result, start must be ignored
        bus.result_ready = 1'b0;
        run_job(3, -1, 0, res, lat);
        for (int k = 0; k < 10; k++) begin
            bus.start = (k % 2 == 0);
            bus.len   = 8'd5;
            @(negedge clk);
            chk("stall result_valid", bus.result_valid, 1);
            chk("stall result", bus.result, 48'd19);
            chk("stall start_ready", bus.start_ready, 0);
        end
        bus.start = 1'b0;
        bus.result_ready = 1'b1;
        @(negedge clk);
        chk("stall release", bus.result_valid, 0);

        // full-length jobs of max-positive operands, twice
        for (int i = 0; i < 255; i++) begin pa[i] = 18'h1FFFF; pb[i] = 18'h1FFFF; end
        run_job(255, -1, 0, res, lat);
        chk("len255 result", res, 48'd4380799795455);
        run_job(255, -1, 0, res2, lat);
        chk("len255 repeat", res2, 48'd4380799795455);

        // reset in the middle of a job
        @(negedge clk);
        bus.start = 1'b1; bus.len = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.s_valid = 1'b1; bus.s_a = 18'd9; bus.s_b = 18'd9;
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        chk("busy before reset", bus.busy, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst busy", bus.busy, 0);
        chk("midrst result", bus.result, 0);
        chk("midrst dsp_a", bus.dsp_a, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        pa[0] = 18'd6; pb[0] = 18'd7;
        run_job(1, -1, 0, res, lat);
        chk("post-reset result", res, 48'd42);
        chk("post-reset latency", lat, 4);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Sequencer that drives one DSP48A1 slice as a streaming multiply-accumulate engine.
- Accepts a start command with a length, then streams A/B operand pairs into the slice.
- Issues the per-cycle opmode: first product, accumulate, or hold.
- Tracks the slice pipeline with a tag shift register, captures P when the last product lands, and returns the dot-product result over a valid/ready handshake.

Parameters:
- LEN_W, 8, width of the length field; maximum 2^LEN_W-1 pairs per job.
- MUL_LAT, 2, cycles from operand on dsp_a/dsp_b to product valid at M output. Matches A1REG=B1REG=MREG=1, A0REG=B0REG=0.
- OPM_LAT, 1, opmode register depth in the slice (OPMODEREG).
- P_LAT, 1, post-adder output register depth (PREG).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job request; accepted only when start_ready=1
- start_ready  out  1  high in IDLE
- len  in  LEN_W  number of operand pairs, sampled on start accept
- s_valid  in  1  operand pair valid
- s_ready  out  1  sequencer accepts the pair
- s_a  in  18  multiplicand
- s_b  in  18  multiplier
- dsp_a  out  18  to slice A
- dsp_b  out  18  to slice B
- dsp_opmode  out  8  to slice opmode
- dsp_ce  out  1  drives CEA/CEB/CEM/CEP/CEOPMODE together
- dsp_p  in  48  slice P output
- result  out  48  accumulated dot product
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset values: start_ready=0 while rst_n low, then 1; s_ready=0; dsp_a=dsp_b=0; dsp_opmode=0x00; dsp_ce=1; result=0; result_valid=0; busy=0. All tags are cleared.
- Opmode encodings (bit7 add, bit6/4/5 zero):
  - FIRST=0x01 (X=M, Z=0)
  - ACC=0x09 (X=M, Z=P)
  - HOLD=0x08 (X=0, Z=P)
  - IDLE=0x00
- State IDLE: start_ready=1.
  - start with len>0: latch remaining count=len, go to RUN.
  - start with len=0: result=0, result_valid=1, go to RESULT. No slice activity.
- State RUN: s_ready=1.
  - On s_valid&s_ready: dsp_a/dsp_b<=s_a/s_b, push tag {v=1, first, last}, decrement count.
  - No beat: push bubble tag {v=0}; dsp_a/dsp_b are don't-care.
  - When the last pair is accepted, go to DRAIN.
- Tag pipeline: depth MUL_LAT+P_LAT.
  - The tag at stage MUL_LAT-OPM_LAT selects dsp_opmode: FIRST if v&first, ACC if v&!first, HOLD if v=0.
  - The opmode is therefore applied exactly when the tagged product is at M.
- State DRAIN: s_ready=0, bubbles pushed. When the last tag exits stage MUL_LAT+P_LAT: result<=dsp_p, result_valid=1, go to RESULT.
- State RESULT: result_valid and result are held stable until result_ready. Then result_valid=0, go to IDLE.
- Latency: result_valid rises MUL_LAT+P_LAT+1 cycles after the last pair is accepted (4 with defaults).
- Bubbles mid-job leave P unchanged (HOLD), so gaps in s_valid do not alter the result.
- start while not IDLE is ignored (start_ready=0). A new job cannot overlap a pending result.
- Arithmetic: products are signed 18x18 from the slice. Accumulation wraps modulo 2^48 in the slice; no saturation.
- rst_n asserted mid-job: immediate return to reset values; in-flight tags and the partial result are discarded.

Optional Feature:
- Macro: DSP_MAC_SEQ_PREADD_EN.
- Defined:
  - Adds input port s_d (18 bits), registered to dsp_d (18 bits, out).
  - Opmode bit4 is set for all FIRST/ACC/HOLD codes: FIRST=0x11, ACC=0x19, HOLD=0x18.
  - The slice computes sum a*(d+b), for symmetric-FIR use.
- Undefined: no s_d/dsp_d ports; bit4=0 always.

Test Plan:
- len=3, pairs (2,3),(4,5),(-1,7) back-to-back, result_ready=1 -> result=19. result_valid pulses 1 cycle, 4 cycles after the last accept.
- Same job with s_valid low for 2 cycles between pairs 1 and 2 -> result=19. dsp_opmode shows 0x08 for the two bubble cycles.
- len=0 start -> result_valid=1 next cycle, result=0, no non-zero opmode issued.
- result_ready held low 10 cycles after result -> result and result_valid stable. start ignored, start_ready=0 throughout.
- len=255, all pairs (0x1FFFF,0x1FFFF) -> result=255*131071^2 mod 2^48. Two jobs back-to-back give identical results, confirming the FIRST opmode clears the accumulator.
- rst_n pulsed low mid-RUN after 2 pairs -> all outputs return to reset values. A subsequent len=1 (6,7) job gives 42.
